// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC mux selection
// codes, FSM state encoding and default interrupt/trap vector addresses.
package pc_sequencer_pkg;

    localparam logic [3:0] SEL_SEQ    = 4'd0;
    localparam logic [3:0] SEL_TARGET = 4'd1;
    localparam logic [3:0] SEL_BOOT   = 4'd2;
    localparam logic [3:0] SEL_IRQ    = 4'd3;
    localparam logic [3:0] SEL_TRAP   = 4'd4;

    localparam int VEC_IRQ_DEFAULT  = 96;
    localparam int VEC_TRAP_DEFAULT = 97;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the external next-PC mux and registers its result.
// Interrupt support is compiled in only when PC_SEQUENCER_IRQ_EN is defined.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH    = 17,
    parameter int VEC_IRQ  = VEC_IRQ_DEFAULT,
    parameter int VEC_TRAP = VEC_TRAP_DEFAULT
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Trap,
    input  logic             Eret,
    input  logic             Halt,
    input  logic             IrqReq,
    output logic             IrqAck,
    input  logic [WIDTH-1:0] NextPc,
    output logic [3:0]       Selection,
    output logic [WIDTH-1:0] PcPlus1,
    output logic [WIDTH-1:0] Target,
    output logic [WIDTH-1:0] Pc,
    output state_t           DbgState,
    output logic [WIDTH-1:0] DbgEpc,
    output logic             DbgIe
);

    // The vectors are consumed by the external mux; reject values it cannot carry.
    if ((VEC_IRQ >= (1 << WIDTH)) || (VEC_TRAP >= (1 << WIDTH))) begin : g_vec_range
        $error("pc_sequencer: vector address does not fit in WIDTH bits");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             ie_q, ie_d;
    logic             irq_run;
    logic             irq_halt;

`ifdef PC_SEQUENCER_IRQ_EN
    // A branch in the same cycle defers the interrupt so the branch is not lost.
    assign irq_run  = IrqReq & ie_q & ~Branch;
    assign irq_halt = IrqReq & ie_q;
`else
    logic unused_irq;
    assign unused_irq = IrqReq;
    assign irq_run    = 1'b0;
    assign irq_halt   = 1'b0;
`endif

    assign PcPlus1 = pc_q + WIDTH'(1);
    assign Target  = Eret ? epc_q : BranchTarget;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            epc_q   <= '0;
            ie_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        ie_d      = ie_q;
        Selection = SEL_SEQ;
        IrqAck    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                Selection = SEL_BOOT;
                pc_d      = NextPc;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (Trap) begin
                        Selection = SEL_TRAP;
                        epc_d     = pc_q;
                        ie_d      = 1'b0;
                        pc_d      = NextPc;
                    end else if (irq_run) begin
                        Selection = SEL_IRQ;
                        epc_d     = PcPlus1;
                        ie_d      = 1'b0;
                        IrqAck    = 1'b1;
                        pc_d      = NextPc;
                    end else if (Eret) begin
                        Selection = SEL_TARGET;
                        ie_d      = 1'b1;
                        pc_d      = NextPc;
                    end else if (Branch) begin
                        Selection = SEL_TARGET;
                        pc_d      = NextPc;
                    end else if (Halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = NextPc;
                    end
                end
            end
            ST_HALTED: begin
                // Resume point is the halt instruction itself, so Epc takes Pc here.
                if (irq_halt) begin
                    Selection = SEL_IRQ;
                    epc_d     = pc_q;
                    ie_d      = 1'b0;
                    IrqAck    = 1'b1;
                    pc_d      = NextPc;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign Pc       = pc_q;
    assign DbgState = state_q;
    assign DbgEpc   = epc_q;
    assign DbgIe    = ie_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, checked against a behavioural model of the sequencing rules.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int WIDTH    = 17;
    localparam int MOD      = 1 << WIDTH;
    localparam int VEC_IRQ  = 96;
    localparam int VEC_TRAP = 97;
`ifdef PC_SEQUENCER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic             Clock = 1'b0;
    logic             ResetN;
    logic             Stall, Branch, Trap, Eret, Halt, IrqReq;
    logic [WIDTH-1:0] BranchTarget;
    logic             IrqAck;
    logic [WIDTH-1:0] NextPc;
    logic [3:0]       Selection;
    logic [WIDTH-1:0] PcPlus1, Target, Pc, DbgEpc;
    state_t           DbgState;
    logic             DbgIe;

    // clock / reset
    always #5 Clock = ~Clock;

    // external next-PC mux
    always_comb begin
        case (Selection)
            4'd0:    NextPc = PcPlus1;
            4'd1:    NextPc = Target;
            4'd2:    NextPc = WIDTH'(1);
            4'd3:    NextPc = WIDTH'(VEC_IRQ);
            4'd4:    NextPc = WIDTH'(VEC_TRAP);
            default: NextPc = '0;
        endcase
    end

    pc_sequencer #(.WIDTH(WIDTH), .VEC_IRQ(VEC_IRQ), .VEC_TRAP(VEC_TRAP)) dut (
        .Clock(Clock), .ResetN(ResetN), .Stall(Stall), .Branch(Branch),
        .BranchTarget(BranchTarget), .Trap(Trap), .Eret(Eret), .Halt(Halt),
        .IrqReq(IrqReq), .IrqAck(IrqAck), .NextPc(NextPc), .Selection(Selection),
        .PcPlus1(PcPlus1), .Target(Target), .Pc(Pc), .DbgState(DbgState),
        .DbgEpc(DbgEpc), .DbgIe(DbgIe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_pc, m_epc, m_st;
    bit m_ie;
    logic [WIDTH-1:0] exp_q[$];

    function automatic state_t exp_state(input int s);
        case (s)
            M_BOOT:  return ST_BOOT;
            M_RUN:   return ST_RUN;
            default: return ST_HALTED;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_epc = 0;
        m_ie  = 1'b1;
        m_st  = M_BOOT;
        exp_q.delete();
    endtask

    // Asynchronous reset pulse a few ns after an edge; checked before the next edge.
    task automatic async_reset();
        #2;
        ResetN = 1'b0;
        #1;
        model_reset();
        check("rst_pc", Pc, 0);
        check("rst_sel", Selection, 2);
        check("rst_ack", IrqAck, 0);
        check("rst_epc", DbgEpc, 0);
        check("rst_ie", DbgIe, 1);
        check("rst_state", DbgState, exp_state(M_BOOT));
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, check registers after the edge.
    task automatic cycle(input bit stall, input bit br, input bit trap, input bit eret,
                         input bit halt, input bit irq, input int bt);
        int sel;
        bit ack;
        int old_pc, old_epc;
        Stall        = stall;
        Branch       = br;
        Trap         = trap;
        Eret         = eret;
        Halt         = halt;
        IrqReq       = irq;
        BranchTarget = WIDTH'(bt);
        old_pc  = m_pc;
        old_epc = m_epc;
        sel = 0;
        ack = 1'b0;
        case (m_st)
            M_BOOT: begin
                sel = 2; m_pc = 1; m_st = M_RUN;
            end
            M_RUN: begin
                if (!stall) begin
                    if (trap) begin
                        sel = 4; m_epc = m_pc; m_ie = 1'b0; m_pc = VEC_TRAP;
                    end else if (IRQ_EN && irq && m_ie && !br) begin
                        sel = 3; ack = 1'b1; m_epc = (m_pc + 1) % MOD; m_ie = 1'b0; m_pc = VEC_IRQ;
                    end else if (eret) begin
                        sel = 1; m_ie = 1'b1; m_pc = m_epc;
                    end else if (br) begin
                        sel = 1; m_pc = bt % MOD;
                    end else if (halt) begin
                        m_st = M_HALT;
                    end else begin
                        m_pc = (m_pc + 1) % MOD;
                    end
                end
            end
            default: begin
                if (IRQ_EN && irq && m_ie) begin
                    sel = 3; ack = 1'b1; m_epc = m_pc; m_ie = 1'b0; m_pc = VEC_IRQ; m_st = M_RUN;
                end
            end
        endcase
        exp_q.push_back(WIDTH'(m_pc));
        @(negedge Clock);
        check("sel", Selection, sel);
        check("ack", IrqAck, ack);
        check("pcplus1", PcPlus1, (old_pc + 1) % MOD);
        check("target", Target, eret ? old_epc : bt % MOD);
        @(posedge Clock);
        #1;
        check("pc", Pc, exp_q.pop_front());
        check("epc", DbgEpc, m_epc);
        check("ie", DbgIe, m_ie);
        check("state", DbgState, exp_state(m_st));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ResetN = 1'b0;
        Stall = 0; Branch = 0; Trap = 0; Eret = 0; Halt = 0; IrqReq = 0;
        BranchTarget = '0;
        model_reset();
        @(posedge Clock);
        #1;
        async_reset();

        // boot then sequential 1, 2, 3
        idle(); idle(); idle();

        // branch, stalled branch, branch
        cycle(0, 1, 0, 0, 0, 0, 'h10);
        cycle(1, 1, 0, 0, 0, 0, 'h200);
        cycle(0, 1, 0, 0, 0, 0, 'h200);

        // interrupt at 0x20, held request, then return
        cycle(0, 1, 0, 0, 0, 0, 'h20);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 1, 0);
        idle();

        // trap wins over interrupt and branch
        cycle(0, 1, 0, 0, 0, 0, 'h30);
        cycle(0, 1, 1, 0, 0, 1, 'h55);
        cycle(0, 0, 0, 1, 0, 0, 0);

        // wrap, halt, ignored inputs in halt, interrupt out of halt
        cycle(0, 1, 0, 0, 0, 0, 'h1FFFF);
        idle();
        cycle(0, 1, 0, 0, 0, 0, 'h40);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 'h123);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // async reset while halted
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        async_reset();
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (m_st == M_HALT && $urandom_range(0, 5) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, MOD - 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 17, the program-counter width in bits.
REQ-002 The block SHALL have parameter VEC_IRQ, default 96, the interrupt vector address, selected by Selection code 3.
REQ-003 The block SHALL have parameter VEC_TRAP, default 97, the trap vector address, selected by Selection code 4.
REQ-004 Clock  input  1  single system clock, rising edge.
REQ-005 ResetN  input  1  reset, asynchronous, active-low.
REQ-006 Stall  input  1  hold the PC this cycle.
REQ-007 Branch  input  1  take BranchTarget.
REQ-008 BranchTarget  input  WIDTH  branch/jump destination.
REQ-009 Trap  input  1  the current instruction faults.
REQ-010 Eret  input  1  return from exception/interrupt.
REQ-011 Halt  input  1  the current instruction is a halt.
REQ-012 IrqReq  input  1  level interrupt request.
REQ-013 IrqAck  output  1  one-cycle pulse when the interrupt is taken.
REQ-014 NextPc  input  WIDTH  next-PC mux result, fed back.
REQ-015 Selection  output  4  next-PC mux code: 0 PcPlus1, 1 Target, 2 boot address 1, 3 VEC_IRQ, 4 VEC_TRAP.
REQ-016 PcPlus1  output  WIDTH  Pc+1, driven to mux input 0.
REQ-017 Target  output  WIDTH  Epc when Eret=1, else BranchTarget; driven to mux input 1.
REQ-018 Pc  output  WIDTH  current program counter (register).

Function
REQ-019 Selection, IrqAck, PcPlus1 and Target SHALL be combinational from the state, the registers and the inputs; Pc SHALL load NextPc on the rising edge ending any cycle marked "advance".
REQ-020 PcPlus1 SHALL wrap modulo 2^WIDTH: 0x1FFFF -> 0x00000.
REQ-021 The FSM SHALL have three states: BOOT, RUN and HALTED.
REQ-022 In BOOT, Selection SHALL be 2, the cycle SHALL advance with Stall ignored, and the next state SHALL be RUN.
REQ-023 In RUN with Stall=1, the cycle SHALL NOT advance: Pc, Epc, Ie and the state hold, IrqAck=0 and Selection=0.
REQ-024 In RUN with Stall=0, the cycle SHALL advance using the first matching rule of this priority: Trap > Irq > Eret > Branch > Halt > sequential.
REQ-025 On Trap, Selection SHALL be 4, Epc SHALL load Pc and Ie SHALL clear.
REQ-026 An interrupt SHALL be taken when IrqReq=1, Ie=1 and Branch=0; then Selection=3, Epc loads PcPlus1, Ie clears and IrqAck=1 for that cycle; if Branch=1 the interrupt is deferred.
REQ-027 On Eret, Selection SHALL be 1 (Target=Epc) and Ie SHALL set.
REQ-028 On Branch, Selection SHALL be 1 (Target=BranchTarget).
REQ-029 On Halt, Selection SHALL be 0, Pc SHALL NOT load and the next state SHALL be HALTED.
REQ-030 Otherwise Selection SHALL be 0 and Pc SHALL load PcPlus1.
REQ-031 In HALTED, Pc SHALL hold and Trap, Branch, Eret and Stall SHALL be ignored.
REQ-032 In HALTED, an interrupt with IrqReq=1 and Ie=1 SHALL apply the REQ-026 actions (Epc loads Pc) and the next state SHALL be RUN.
REQ-033 IrqAck SHALL never assert on two consecutive cycles, because Ie clears on entry.

Reset
REQ-034 While ResetN=0: state=BOOT, Pc=0, Epc=0, Ie=1; hence Selection=2 and IrqAck=0.
REQ-035 Assertion of ResetN mid-operation (including HALTED or during a pending IrqReq) SHALL apply REQ-034 immediately, without waiting for Clock.

Configuration
REQ-036 With macro PC_SEQUENCER_IRQ_EN defined, interrupt logic per REQ-026/032 SHALL be present.
REQ-037 Without PC_SEQUENCER_IRQ_EN, IrqReq SHALL be ignored, IrqAck SHALL be tied 0, Selection 3 SHALL never be produced, and HALTED SHALL exit only by reset.

Structure
REQ-038 A shared package SHALL hold the Selection code constants (SEL_SEQ=0, SEL_TARGET=1, SEL_BOOT=2, SEL_IRQ=3, SEL_TRAP=4), the FSM state enum, and the default vector values 96/97.
REQ-039 The block SHALL be a single module with no sub-module; the next-PC mux remains external, driven by Selection/PcPlus1/Target and returning NextPc.

Verification
REQ-040 Reset then release, no events -> Selection=2 in the first cycle, then Pc = 1, 2, 3 on successive edges.
REQ-041 Pc=0x00010 with Branch=1, BranchTarget=0x00200 -> Selection=1 and Pc=0x00200 after one edge; with Stall=1 as well -> Pc stays 0x00010.
REQ-042 Pc=0x00020 with IrqReq=1 (IRQ_EN defined) -> IrqAck pulses once, Pc=96, Epc=0x00021; IrqReq held -> no second ack; Eret -> Pc=0x00021 and Ie=1.
REQ-043 Pc=0x00030 with Trap=1, IrqReq=1 and Branch=1 together -> Selection=4, Pc=97, Epc=0x00030, IrqAck=0.
REQ-044 Pc=0x1FFFF sequential -> Pc=0x00000; Halt at 0x00040 -> Pc holds at 0x00040; then IrqReq=1 -> Pc=96, Epc=0x00040, state RUN.
REQ-045 ResetN pulsed low asynchronously mid-cycle while HALTED -> Pc=0 and Selection=2 before the next Clock edge.
